// File: rtl/counter_wrap_monitor.sv
// counter_wrap_monitor: checks a 4-bit counter/overflow stream, counts wraps, ticks epochs, latches faults (optional err_count via WRAP_MON_ERRCNT_EN)
module counter_wrap_monitor #(
  parameter int WRAP_W      = 16,
  parameter int EPOCH_WRAPS = 4,
  parameter int LOCK_LEN    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [3:0]        cnt_in,
  input  logic              ovf_in,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              epoch_tick,
  output logic              locked,
  output logic              seq_err,
  output logic              ovf_err,
  output logic [1:0]        state
`ifdef WRAP_MON_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);
  typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKED = 2'd1, FAULT = 2'd2} state_t;
`ifdef WRAP_MON_ERRCNT_EN
  localparam state_t ERR_ST = UNLOCKED;
`else
  localparam state_t ERR_ST = FAULT;
`endif
  state_t     st, nxt;
  logic       prev_valid;
  logic [3:0] prev_cnt, inc, lock_cnt;
  logic [4:0] lock_nxt;
  logic [7:0] epoch_cnt;
  logic [8:0] epoch_nxt;
  logic       good_inc, exp_ovf, bad_seq, bad_ovf, wrap, lock_hit, epoch_hit;
  assign state = st;
  // Per-sample consistency checks and next-state decision
  always_comb begin
    inc       = prev_cnt + 4'd1;
    good_inc  = prev_valid && (cnt_in == inc);
    exp_ovf   = prev_valid && (prev_cnt == 4'hf) && (cnt_in == 4'h0);
    bad_seq   = (st == LOCKED) && !good_inc;
    bad_ovf   = (st == LOCKED) && (ovf_in != exp_ovf);
    wrap      = (st == LOCKED) && !bad_seq && !bad_ovf && ovf_in;
    lock_nxt  = {1'b0, lock_cnt} + 5'd1;
    lock_hit  = (st == UNLOCKED) && good_inc && (lock_nxt == 5'(LOCK_LEN));
    epoch_nxt = {1'b0, epoch_cnt} + 9'd1;
    epoch_hit = wrap && (epoch_nxt == 9'(EPOCH_WRAPS));
    nxt = (st == UNLOCKED) ? (lock_hit ? LOCKED : UNLOCKED)
        : (st == LOCKED)   ? ((bad_seq || bad_ovf) ? ERR_ST : LOCKED)
        : st;
  end
  // Registered state, counters and sticky flags; clear outranks every event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= UNLOCKED;
      locked     <= 1'b0;
      prev_valid <= 1'b0;
      prev_cnt   <= 4'd0;
      lock_cnt   <= 4'd0;
      epoch_cnt  <= 8'd0;
      wrap_count <= '0;
      epoch_tick <= 1'b0;
      seq_err    <= 1'b0;
      ovf_err    <= 1'b0;
`ifdef WRAP_MON_ERRCNT_EN
      err_count  <= 8'd0;
`endif
    end else if (clear) begin
      st         <= UNLOCKED;
      locked     <= 1'b0;
      prev_valid <= 1'b0;
      lock_cnt   <= 4'd0;
      epoch_cnt  <= 8'd0;
      wrap_count <= '0;
      epoch_tick <= 1'b0;
      seq_err    <= 1'b0;
      ovf_err    <= 1'b0;
`ifdef WRAP_MON_ERRCNT_EN
      err_count  <= 8'd0;
`endif
    end else begin
      st         <= nxt;
      locked     <= (nxt == LOCKED);
      prev_valid <= 1'b1;
      prev_cnt   <= cnt_in;
      lock_cnt   <= ((st == UNLOCKED) && good_inc && !lock_hit) ? lock_nxt[3:0] : 4'd0;
      epoch_cnt  <= epoch_hit ? 8'd0 : wrap ? epoch_nxt[7:0] : epoch_cnt;
      wrap_count <= wrap ? wrap_count + WRAP_W'(1) : wrap_count;
      epoch_tick <= epoch_hit;
      seq_err    <= seq_err | bad_seq;
      ovf_err    <= ovf_err | bad_ovf;
`ifdef WRAP_MON_ERRCNT_EN
      err_count  <= ((bad_seq || bad_ovf) && (err_count != 8'hff)) ? err_count + 8'd1 : err_count;
`endif
    end
  end
endmodule

// File: tb/tb_counter_wrap_monitor.sv
// tb_counter_wrap_monitor: directed plus randomized checks of counter_wrap_monitor against a behavioural model
module tb_counter_wrap_monitor;
  localparam int W = 16, EPOCH = 4, LOCKN = 2;
`ifdef WRAP_MON_ERRCNT_EN
  localparam int ERR_MODE = 0;
`else
  localparam int ERR_MODE = 2;
`endif
  logic clk = 0, reset = 0, clear = 0, ovf_in = 0;
  logic [3:0] cnt_in = 0;
  logic [W-1:0] wrap_count;
  logic epoch_tick, locked, seq_err, ovf_err;
  logic [1:0] state;
`ifdef WRAP_MON_ERRCNT_EN
  logic [7:0] err_count;
`endif
  int checks = 0, failures = 0;
  int m_last, m_mode, m_streak, m_wraps, m_seq, m_ovf, m_tick, m_err;
  int cur = 0, ticks = 0;
  counter_wrap_monitor #(.WRAP_W(W), .EPOCH_WRAPS(EPOCH), .LOCK_LEN(LOCKN)) dut (
    .clk(clk), .reset(reset), .clear(clear), .cnt_in(cnt_in), .ovf_in(ovf_in),
    .wrap_count(wrap_count), .epoch_tick(epoch_tick), .locked(locked),
    .seq_err(seq_err), .ovf_err(ovf_err), .state(state)
`ifdef WRAP_MON_ERRCNT_EN
    , .err_count(err_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_last = -1; m_mode = 0; m_streak = 0; m_wraps = 0;
    m_seq = 0; m_ovf = 0; m_tick = 0; m_err = 0;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state), m_mode);
    chk({tag, ".locked"}, 32'(locked), m_mode == 1);
    chk({tag, ".wrap_count"}, 32'(wrap_count), m_wraps);
    chk({tag, ".epoch_tick"}, 32'(epoch_tick), m_tick);
    chk({tag, ".seq_err"}, 32'(seq_err), m_seq);
    chk({tag, ".ovf_err"}, 32'(ovf_err), m_ovf);
`ifdef WRAP_MON_ERRCNT_EN
    chk({tag, ".err_count"}, 32'(err_count), m_err);
`endif
  endtask
  // One sample: drive, advance the model by the stated rules, clock, compare
  task automatic cyc(input int c, input bit o, input bit cl, input string tag);
    bit good, wrapev, bs, bo;
    cnt_in = 4'(c); ovf_in = o; clear = cl;
    if (cl) model_reset();
    else begin
      good = (m_last >= 0) && (c == (m_last + 1) % 16);
      wrapev = (m_last == 15) && (c == 0);
      m_tick = 0;
      if (m_mode == 0) begin
        m_streak = good ? m_streak + 1 : 0;
        if (m_streak == LOCKN) begin m_mode = 1; m_streak = 0; end
      end else if (m_mode == 1) begin
        bs = !good; bo = (o != wrapev);
        if (bs) m_seq = 1;
        if (bo) m_ovf = 1;
        if (bs || bo) begin
          if (m_err < 255) m_err++;
          m_mode = ERR_MODE;
        end else if (wrapev) begin
          m_wraps = (m_wraps + 1) % (1 << W);
          m_tick = (m_wraps % EPOCH) == 0;
        end
      end
      m_last = c;
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask
  task automatic up(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cur = (cur + 1) % 16;
      cyc(cur, cur == 0, 0, tag);
      ticks += int'(epoch_tick);
    end
  endtask
  initial begin
    model_reset();
    #1 reset = 1;
    #2 check_all("reset");
    @(posedge clk); @(posedge clk); #1 reset = 0;
    cur = 0;
    cyc(0, 0, 0, "start0");
    up(1, "start1");
    chk("not_locked_at_1", 32'(locked), 0);
    up(1, "start2");
    chk("locked_at_2", 32'(locked), 1);
    ticks = 0;
    up(64, "freerun");
    chk("wraps_64", 32'(wrap_count), 4);
    chk("ticks_64", ticks, 1);
    while (cur != 6) up(1, "to6");
    cur = 8;
    cyc(8, 0, 0, "skip8");
    chk("skip_seq_err", 32'(seq_err), 1);
    chk("skip_state", 32'(state), ERR_MODE);
    up(5, "hold");
    chk("frozen_wraps", 32'(wrap_count), 4);
    cur = (cur + 1) % 16;
    cyc(cur, 0, 1, "clear1");
    chk("clear_state", 32'(state), 0);
    up(3, "relock1");
    while (cur != 15) up(1, "to15");
    cur = 0;
    cyc(0, 0, 0, "miss_ovf");
    chk("miss_ovf_err", 32'(ovf_err), 1);
    chk("miss_ovf_seq", 32'(seq_err), 0);
    cur = 1;
    cyc(1, 0, 1, "clear2");
    up(3, "relock2");
    while (cur != 6) up(1, "to6b");
    cur = 7;
    cyc(7, 1, 0, "spur_ovf");
    chk("spur_ovf_err", 32'(ovf_err), 1);
    chk("spur_ovf_seq", 32'(seq_err), 0);
    cyc(8, 0, 1, "clear3");
    cur = 8;
    up(3, "relock3");
    while (cur != 15) up(1, "to15b");
    cur = 0;
    cyc(0, 1, 1, "clear_wrap");
    chk("clear_wrap_count", 32'(wrap_count), 0);
    chk("clear_wrap_tick", 32'(epoch_tick), 0);
    up(3, "relock4");
    cur = (cur + 5) % 16;
    cyc(cur, 1, 1, "clear_skip");
    chk("clear_skip_flags", {30'b0, seq_err, ovf_err}, 0);
    chk("clear_skip_state", 32'(state), 0);
    up(20, "pre_async");
    #3 reset = 1;
    #1 model_reset();
    check_all("async_reset");
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      bit o;
      bit cl = 0;
      cur = (cur + 1) % 16;
      o = (cur == 0);
      if (r < 4) cur = (cur + $urandom_range(1, 15)) % 16;
      else if (r < 7) o = !o;
      else if (r < 9) cl = 1;
      if (r < 7 && cur == 0) o = $urandom_range(0, 1);
      cyc(cur, o, cl, "rand");
    end
`ifdef WRAP_MON_ERRCNT_EN
    cyc(cur, 0, 1, "clear_ec");
    up(3, "lock_ec");
    for (int i = 0; i < 300; i++) begin
      cur = (cur + 2) % 16;
      cyc(cur, 0, 0, "ec_skip");
      up(LOCKN, "ec_relock");
    end
    chk("err_count_sat", 32'(err_count), 255);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_wrap_monitor.md
Name: counter_wrap_monitor

Overview:
- Downstream consumer of the free-running 4-bit counter and its overflow flag.
- Checks every cycle that the counter sequence and overflow pulse are self-consistent.
- Accumulates wrap events into a wide wrap count and emits a periodic epoch tick.
- Latches sticky fault flags for system health status.

Parameters:
- WRAP_W, 16: width of wrap_count.
- EPOCH_WRAPS, 4: number of wraps per epoch_tick pulse; legal range 1..255.
- LOCK_LEN, 2: consecutive good increments needed to enter LOCKED; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous: clears flags/counts and returns to UNLOCKED.
- cnt_in  in  4  counter value from the upstream 4-bit counter.
- ovf_in  in  1  overflow flag from the upstream counter.
- wrap_count  out  WRAP_W  number of valid wraps seen while LOCKED.
- epoch_tick  out  1  one-cycle pulse every EPOCH_WRAPS valid wraps.
- locked  out  1  high while the FSM is in LOCKED.
- seq_err  out  1  sticky: counter did not increment by 1 mod 16.
- ovf_err  out  1  sticky: ovf_in inconsistent with the counter sequence.
- state  out  2  FSM state: 0=UNLOCKED, 1=LOCKED, 2=FAULT.

Behaviour:
- Reset is asynchronous and active-high on reset; clock is clk. Reset drives:
  - all outputs to 0, state to UNLOCKED;
  - prev_valid=0, prev_cnt=0, lock_cnt=0, epoch_cnt=0.
- All inputs are sampled on the rising edge of clk. Outputs are registered and reflect the sample taken at that same edge; there are no combinational input-to-output paths.
- good_inc = prev_valid && (cnt_in == prev_cnt+1 mod 16).
- exp_ovf = prev_valid && (prev_cnt==15) && (cnt_in==0). Upstream overflow is high in the cycle its count reads 0 after 15.
- Every non-clear cycle: prev_cnt<=cnt_in; prev_valid<=1.
- UNLOCKED:
  - good_inc: lock_cnt++. Otherwise lock_cnt<=0.
  - When lock_cnt reaches LOCK_LEN: go to LOCKED and clear lock_cnt.
  - ovf_in is ignored, and wraps are not counted.
- LOCKED:
  - !good_inc: set seq_err, go to FAULT.
  - ovf_in != exp_ovf: set ovf_err, go to FAULT.
  - Both errors in the same cycle: set both flags.
  - ovf_in && exp_ovf: wrap_count++ (wraps modulo 2^WRAP_W) and epoch_cnt++.
  - When epoch_cnt reaches EPOCH_WRAPS: epoch_tick=1 for exactly one cycle and epoch_cnt<=0.
  - A wrap in the erroring cycle is not counted.
- FAULT:
  - Holds until clear. wrap_count freezes and epoch_tick=0.
  - Inputs are still tracked in prev_cnt.
- clear has priority over all events. On clear:
  - state to UNLOCKED, prev_valid=0;
  - seq_err, ovf_err, wrap_count, epoch_cnt, lock_cnt to 0;
  - epoch_tick=0 that cycle.
- If the upstream counter is reset mid-run, the monitor sees a non-15-to-0 jump and flags seq_err. The system must pulse clear alongside the upstream reset.
- A held or stuck counter (same value two cycles) counts as a seq_err.

Optional Feature:
- Macro: WRAP_MON_ERRCNT_EN.
- Defined:
  - Adds output err_count[7:0], reset/clear to 0.
  - err_count increments once per error cycle in LOCKED and saturates at 255.
  - Errors go to UNLOCKED instead of FAULT (auto-relock). Sticky flags still set.
  - state never reads 2.
- Undefined:
  - No err_count port.
  - Errors go to FAULT as described.

Test Plan:
- Reset, then upstream counts 0,1,2,… from reset release → locked=1 at the edge sampling cnt_in=2; seq_err=ovf_err=0.
- After lock, free-run 64 cycles → wrap_count=4; exactly one epoch_tick, on the cycle sampling the 4th overflow.
- Locked stream 5,6,8 → seq_err=1 and state=2 at the edge sampling 8; wrap_count frozen; clear → state=0, flags=0.
- Locked stream 14,15,0 with ovf_in=0 → ovf_err=1; ovf_in=1 at cnt_in=7 → ovf_err=1, seq_err=0.
- clear asserted in the same cycle as a valid wrap and a seq error → wrap_count=0, flags=0, epoch_tick=0, state=0.
- With WRAP_MON_ERRCNT_EN: 300 injected skips, each followed by relock → err_count=255, state never 2.
